// File: rtl/tmc_spi_slave_if.sv
// rtl/tmc_spi_slave_if.sv - SPI pad and register-port bundle of the temp-board SPI responder
interface tmc_spi_slave_if #(
  parameter int DATA_W = 24
);
  logic              sclk;
  logic              csn;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [6:0]        reg_addr;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              frame_err;

  modport slave (
    input  sclk, csn, mosi, rd_data, rd_valid,
    output miso, miso_oe, reg_addr, rd_req, wr_en, wr_data, frame_err
  );

  modport master (
    output sclk, csn, mosi, rd_data, rd_valid,
    input  miso, miso_oe, reg_addr, rd_req, wr_en, wr_data, frame_err
  );
endinterface

// File: rtl/tmc_spi_slave.sv
// rtl/tmc_spi_slave.sv - mode-0 SPI responder serving single-word register reads/writes
module tmc_spi_slave #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  tmc_spi_slave_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, RD_DATA, WR_DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [6:0]        reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              miso_q, miso_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_pend_q, wr_pend_d;
  logic              wr_en_q;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] rd_word;

  // csn chain resets low so a frame still in progress at reset release is not mistaken for a new one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], bus.csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      miso_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      miso_q      <= miso_d;
      rd_req_q    <= rd_req_d;
      wr_pend_q   <= wr_pend_d;
      wr_en_q     <= wr_pend_q;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    miso_d      = miso_q;
    rd_req_d    = 1'b0;
    wr_pend_d   = 1'b0;
    frame_err_d = 1'b0;
    rd_word     = bus.rd_valid ? bus.rd_data : '0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (csn_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        miso_d = 1'b0;
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          shreg_d   = {shreg_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            reg_addr_d = {shreg_q[5:0], mosi_s};
            bit_cnt_d  = '0;
            if (shreg_q[6]) begin
              rd_req_d = 1'b1;
              state_d  = RD_WAIT;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
      end
      RD_WAIT: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_fall) begin
          // the fall that should present the MSB counts as data bit one, even for a late read
          miso_d      = rd_word[DATA_W-1];
          shreg_d     = {rd_word[DATA_W-2:0], 1'b0};
          bit_cnt_d   = CNT_W'(1);
          frame_err_d = ~bus.rd_valid;
          state_d     = RD_DATA;
        end else if (bus.rd_valid) begin
          shreg_d   = bus.rd_data;
          bit_cnt_d = '0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_fall) begin
          miso_d    = shreg_q[DATA_W-1];
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        end
      end
      WR_DATA: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          shreg_d   = {shreg_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            wr_data_d = {shreg_q[DATA_W-2:0], mosi_s};
            wr_pend_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        // the last read bit stays on miso until the master's closing fall
        if (sclk_fall || csn_rise) miso_d = 1'b0;
        if (csn_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.miso_oe = (state_q != IDLE) && !csn_s;
    bus.miso    = miso_q;
  end

  assign bus.reg_addr  = reg_addr_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: doc/tmc_spi_slave.md
Name: tmc_spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0) sitting opposite the Nios SPI master on a temp-board link; used for loopback self-test and temp-board emulation.
- Oversamples SCLK/CSn/MOSI with the logic clock.
- Decodes a command byte and serves single-word register reads and writes through a simple request/valid register port.

Parameters:
- DATA_W, 24: data-phase word width in bits (8..32).
- SYNC_STAGES, 2: synchronizer depth on sclk, csn and mosi (>=2).

Ports:
- clk  in  1  logic clock; must be at least 8x the SCLK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master.
- csn  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  high while csn is low; drives the pad tri-state.
- reg_addr  out  7  address from the command byte; held until the next frame.
- rd_req  out  1  one-cycle read request pulse.
- rd_data  in  DATA_W  read word.
- rd_valid  in  1  rd_data valid; sampled in the RD_WAIT state.
- wr_en  out  1  one-cycle write strobe.
- wr_data  out  DATA_W  write word; valid when wr_en is high, then held.
- frame_err  out  1  one-cycle pulse on an aborted frame or a late read.

Behaviour:
- Reset values: miso=0, miso_oe=0, reg_addr=0, rd_req=0, wr_en=0, wr_data=0, frame_err=0, state=IDLE.
- Synchronizers: the sclk, csn and mosi inputs each pass through SYNC_STAGES flops. Edge detect on the synchronized sclk gives rise/fall strobes. All following behaviour is relative to the synchronized signals.
- Frame format, MSB first: cmd[7] is R/W (1 = read), cmd[6:0] is the address, then DATA_W data bits.
- Bit timing: MOSI is sampled on each rise strobe. MISO is updated on each fall strobe.
- States:
  - IDLE: miso_oe=0. A csn fall moves to CMD with bit_cnt=0.
  - CMD: shift mosi in on 8 rise strobes. On the 8th rise, reg_addr takes cmd[6:0].
    - Read command: rd_req pulses in the same cycle, then go to RD_WAIT.
    - Write command: go to WR_DATA.
  - RD_WAIT: capture rd_data into the shift register on the first cycle rd_valid=1, then go to RD_DATA.
    - If a fall strobe arrives first: frame_err pulses, the shift register loads 0, go to RD_DATA (master reads all zeros).
  - RD_DATA: on each fall strobe, miso takes shreg MSB and shreg shifts left.
    - The first fall after the command presents data bit DATA_W-1.
    - After DATA_W fall strobes, go to DONE.
  - WR_DATA: shift mosi in on DATA_W rise strobes. On the last one, wr_data takes the word and wr_en pulses 1 cycle later. Go to DONE.
  - DONE: miso=0. Extra SCLK edges are ignored. A csn rise goes to IDLE.
- miso_oe = ~csn (synchronized) in every state except IDLE. miso is held at 0 while in CMD.
- csn rise before frame completion, in any of CMD, RD_WAIT, RD_DATA or WR_DATA:
  - frame_err pulses.
  - No wr_en is issued.
  - Return to IDLE.
  - A csn rise in CMD after 0 bits does not raise frame_err.
- A csn rise in DONE is a normal end of frame: no error.
- Bit counter width is clog2(DATA_W)+1 and it clears on every frame start.
- Back-to-back frames: csn high for 1 synchronized cycle is enough to re-arm IDLE.
- rd_valid outside RD_WAIT is ignored.
- rst_n assertion mid-frame: immediate return to reset values. After reset release the frame is not resumed; the slave waits for the next csn fall.

Test Plan:
- Write frame, DATA_W=24: cmd 0x05, data 0xA5C3F0 at SCLK=clk/10 -> exactly one wr_en pulse, reg_addr=0x05, wr_data=0xA5C3F0, no frame_err.
- Read frame: cmd 0x83, bench returns rd_data=0x123456 with rd_valid 2 cycles after rd_req -> one rd_req pulse, reg_addr=0x03, master samples 0x123456 on MISO.
- Late read: cmd 0x81, rd_valid withheld -> frame_err pulses once at the first data fall edge, master reads 0x000000, state returns to IDLE after csn rise.
- Abort: cmd 0x02 plus 10 data bits, then csn high -> frame_err pulse, no wr_en, next full write frame (0x02, 0x00FFFF) completes correctly.
- Reset mid-read: assert rst_n low during bit 12 of a read -> all outputs at reset values within 1 cycle; the next frame after release decodes normally.
- Back-to-back writes with 1-cycle csn gap, 40 extra SCLK edges after a frame -> two wr_en pulses with correct data, extra edges ignored.
